// File: rtl/pdp8_mri_sequencer.sv
// PDP-8 memory-reference instruction sequencer.
// Runs one AND/TAD/ISZ/DCA/JMS/JMP per start pulse: resolves direct or
// indirect addressing, performs the memory cycles over a single req/ack
// port and returns the updated PC, AC and Link.
// Optional feature macro: PDP8_AUTOINDEX_EN (indirect references through
// 0o0010-0o0017 pre-increment the pointer and write it back).
module pdp8_mri_sequencer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic [5:0]            mri_op_i,
    input  logic                  indirect_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [ADDR_WIDTH-1:0] pc_in_i,
    input  logic [DATA_WIDTH-1:0] ac_in_i,
    input  logic                  link_in_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] pc_out_o,
    output logic [DATA_WIDTH-1:0] ac_out_o,
    output logic                  link_out_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_IND_RD, S_IND_WB, S_OP_RD, S_OP_WR, S_DONE
    } state_e;

    // one-hot opcode bit positions
    localparam int OP_AND = 0, OP_TAD = 1, OP_ISZ = 2, OP_DCA = 3, OP_JMS = 4, OP_JMP = 5;

    state_e                state_q, state_d;
    logic [5:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic                  link_q, link_d;
    logic                  err_q, err_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] pco_q;
    logic [DATA_WIDTH-1:0] aco_q;
    logic                  linko_q;

    // dispatch-by-opcode request shared by IDLE, IND_RD and IND_WB
    logic                  dispatch;
    logic [ADDR_WIDTH-1:0] disp_ea;
    logic [ADDR_WIDTH-1:0] inc_ea;
    logic [DATA_WIDTH:0]   sum;
    logic                  autoinc;

`ifdef PDP8_AUTOINDEX_EN
    logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
    assign autoinc = (iaddr_q >= ADDR_WIDTH'(8)) && (iaddr_q <= ADDR_WIDTH'(15));
`else
    assign autoinc = 1'b0;
`endif

    // next-state, datapath and memory-request logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ea_d     = ea_q;
        pc_d     = pc_q;
        ac_d     = ac_q;
        link_d   = link_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dispatch = 1'b0;
        disp_ea  = ea_q;
        inc_ea   = ADDR_WIDTH'(mem_rdata_i) + ADDR_WIDTH'(1);
        sum      = {1'b0, ac_q} + {1'b0, mem_rdata_i};
`ifdef PDP8_AUTOINDEX_EN
        iaddr_d  = iaddr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d   = mri_op_i;
                    pc_d   = pc_in_i;
                    ac_d   = ac_in_i;
                    link_d = link_in_i;
                    err_d  = 1'b0;
`ifdef PDP8_AUTOINDEX_EN
                    iaddr_d = inst_addr_i;
`endif
                    if (!$onehot(mri_op_i)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (indirect_i) begin
                        state_d = S_IND_RD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = inst_addr_i;
                    end else begin
                        dispatch = 1'b1;
                        disp_ea  = inst_addr_i;
                    end
                end
            end
            S_IND_RD: begin
                if (mem_ack_i) begin
                    if (autoinc) begin
                        // pointer write-back keeps the same address
                        state_d = S_IND_WB;
                        ea_d    = inc_ea;
                        we_d    = 1'b1;
                        wdata_d = DATA_WIDTH'(inc_ea);
                    end else begin
                        dispatch = 1'b1;
                        disp_ea  = ADDR_WIDTH'(mem_rdata_i);
                    end
                end
            end
            S_IND_WB: begin
                if (mem_ack_i) begin
                    dispatch = 1'b1;
                    disp_ea  = ea_q;
                end
            end
            S_OP_RD: begin
                if (mem_ack_i) begin
                    if (op_q[OP_ISZ]) begin
                        state_d = S_OP_WR;
                        we_d    = 1'b1;
                        wdata_d = mem_rdata_i + DATA_WIDTH'(1);
                    end else begin
                        state_d = S_DONE;
                        req_d   = 1'b0;
                        if (op_q[OP_AND]) ac_d = ac_q & mem_rdata_i;
                        if (op_q[OP_TAD]) begin
                            ac_d   = sum[DATA_WIDTH-1:0];
                            link_d = link_q ^ sum[DATA_WIDTH];
                        end
                    end
                end
            end
            S_OP_WR: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    // ISZ skip: written value wrapped to zero
                    if (op_q[OP_ISZ] && (wdata_q == '0)) pc_d = pc_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (dispatch) begin
            ea_d   = disp_ea;
            addr_d = disp_ea;
            req_d  = 1'b1;
            we_d   = 1'b0;
            if (op_d[OP_JMP]) begin
                state_d = S_DONE;
                pc_d    = disp_ea;
                req_d   = 1'b0;
            end else if (op_d[OP_DCA]) begin
                state_d = S_OP_WR;
                we_d    = 1'b1;
                wdata_d = ac_d;
                ac_d    = '0;
            end else if (op_d[OP_JMS]) begin
                state_d = S_OP_WR;
                we_d    = 1'b1;
                wdata_d = DATA_WIDTH'(pc_d);
                pc_d    = disp_ea + ADDR_WIDTH'(1);
            end else begin
                state_d = S_OP_RD;
            end
        end
    end

    // state, working registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ea_q    <= '0;
            pc_q    <= '0;
            ac_q    <= '0;
            link_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pco_q   <= '0;
            aco_q   <= '0;
            linko_q <= 1'b0;
`ifdef PDP8_AUTOINDEX_EN
            iaddr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            link_q  <= link_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef PDP8_AUTOINDEX_EN
            iaddr_q <= iaddr_d;
`endif
            // results published on entry to DONE, held until the next one
            if (state_d == S_DONE) begin
                pco_q   <= pc_d;
                aco_q   <= ac_d;
                linko_q <= link_d;
            end
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_DONE) && err_q;
    assign pc_out_o    = pco_q;
    assign ac_out_o    = aco_q;
    assign link_out_o  = linko_q;

endmodule

// File: doc/pdp8_mri_sequencer.md
# pdp8_mri_sequencer

Multi-cycle controller that executes one PDP-8 memory-reference instruction (AND, TAD, ISZ, DCA, JMS, JMP) per `start` pulse. It resolves direct and indirect addressing and issues the required memory read and write cycles over a single request/acknowledge port. It then returns the updated PC, AC and Link. It sits between the instruction decoder and the shared memory port, and is idle while the decoder handles op7 instructions.

## Interface
- `ADDR_WIDTH`, default 12: address width in bits.
- `DATA_WIDTH`, default 12: data word width in bits.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse. Sampled only in IDLE.
- `mri_op`  in  6  one-hot opcode. Bit 0 AND, 1 TAD, 2 ISZ, 3 DCA, 4 JMS, 5 JMP.
- `indirect`  in  1  I bit of the instruction.
- `inst_addr`  in  12  operand address formed by the decoder (page/zero-page already applied).
- `pc_in`  in  12  PC of the next sequential instruction (already incremented).
- `ac_in`, `link_in`  in  12, 1  current AC and Link.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`, `mem_wdata`  out  12  request address and write data.
- `mem_ack`  in  1  completes the current request. Read data is valid in the same cycle.
- `mem_rdata`  in  12  read data.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse, coincident with `done`, when `mri_op` is not one-hot.
- `pc_out`, `ac_out`, `link_out`  out  12, 12, 1  results. Valid when `done` is high and held until the next `done`.

## Operation
- Reset values: all outputs 0. State is IDLE.
- States: IDLE, IND_RD, IND_WB, OP_RD, OP_WR, DONE.
- **IDLE + `start`:**
  - Latch all inputs.
  - If `mri_op` is not one-hot, go to DONE with `err` set. Results are copied from the inputs unchanged and no memory access occurs.
  - Otherwise, if `indirect`=1, go to IND_RD.
  - Otherwise, for JMP go to DONE; for DCA and JMS go to OP_WR; for all others go to OP_RD.
- **IND_RD:** read `inst_addr`. On `mem_ack`, EA = `mem_rdata`.
  - With auto-index enabled and `inst_addr` in 0o0010–0o0017: EA = `mem_rdata`+1 (mod 4096), then go to IND_WB.
  - Otherwise, proceed by opcode exactly as from IDLE.
- **IND_WB:** write EA to `inst_addr`, then proceed by opcode.
- **Opcode behaviour:**
  - AND: read M; AC = AC & M.
  - TAD: read M; {carry, AC} = AC + M; Link ^= carry.
  - ISZ: read M, write M+1 (mod 4096) in OP_WR. If the written value is 0, PC = `pc_in`+1 (mod 4096).
  - DCA: write AC to EA; AC = 0.
  - JMS: write `pc_in` to EA; PC = EA+1 (mod 4096).
  - JMP: PC = EA.
  - Values not listed for an opcode pass through unchanged.
- All arithmetic is 12-bit, wrapping modulo 4096. Link changes only on a TAD carry.
- **DONE:** assert `done` (and `err` if flagged) for one cycle, then return to IDLE.
- `start` while `busy` is ignored and not queued.

## Timing
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - `mem_req` rises on the first cycle of a memory state.
  - These signals stay stable until the cycle in which `mem_ack` is sampled high, inclusive.
  - `mem_req` falls in the following cycle, unless the next state also accesses memory, in which case `mem_req` stays high with the new address.
- Each access costs 1 cycle plus the number of wait cycles before `mem_ack`. `mem_ack` with `mem_req` low is ignored.
- Latency from `start` (cycle 0) to `done`, assuming zero-wait memory:

  | Instruction | `done` in cycle |
  |---|---|
  | direct JMP | 1 |
  | direct AND/TAD/DCA/JMS | 2 |
  | direct ISZ | 3 |
  | indirect | +1 |
  | auto-index | +1 more |
  | illegal | 1 |

- Reset asserted mid-operation: on the next edge all outputs return to 0, the state goes to IDLE, and the outstanding request is abandoned. The memory must tolerate a dropped request.

## Configuration
- `PDP8_AUTOINDEX_EN` defined: indirect references through 0o0010–0o0017 pre-increment the pointer and write it back via IND_WB.
- `PDP8_AUTOINDEX_EN` undefined: those locations behave as ordinary indirect pointers, and IND_WB is unreachable.

## Test plan
- Direct TAD, AC=0o7777, L=0, M[0o0100]=0o0001, zero-wait memory -> AC=0o0000, L=1, `done` in cycle 2, one read only.
- ISZ, M[0o0200]=0o7777, `pc_in`=0o0301, `mem_ack` delayed 3 cycles per access -> write of 0o0000 to 0o0200, PC=0o0302, `done` in cycle 9.
- Indirect JMS, `inst_addr`=0o0050, M[0o0050]=0o7777, `pc_in`=0o1234 -> write 0o1234 to 0o7777, PC=0o0000 (wrap).
- Indirect DCA through 0o0012 holding 0o0377, AC=0o5252, with `PDP8_AUTOINDEX_EN` -> write 0o0400 to 0o0012, then write 0o5252 to 0o0400, AC=0.
  - Without the macro: write 0o5252 to 0o0377, no pointer update.
- `mri_op`=6'b000011 -> `done` and `err` in cycle 1, no `mem_req`, outputs equal the inputs. A second `start` while `busy` is ignored.
- Assert `reset_n`=0 while `mem_req` is high and waiting -> next cycle `mem_req`=0, `busy`=0, all outputs 0. A new JMP after reset completes normally.
